// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment definitions: segment bit order, digit patterns, error code, filter states.
// Also consumed by the BCD-to-7-segment encoder, so the pattern constants live here once.
package seg7_scan_decoder_pkg;

    // Segment bit positions within a 7-bit pattern {a,b,c,d,e,f,g}
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    localparam logic [6:0] SEG_0  = 7'b1111110;
    localparam logic [6:0] SEG_1  = 7'b0110000;
    localparam logic [6:0] SEG_2  = 7'b1101101;
    localparam logic [6:0] SEG_3  = 7'b1111001;
    localparam logic [6:0] SEG_4  = 7'b0110011;
    localparam logic [6:0] SEG_5  = 7'b1011011;
    localparam logic [6:0] SEG_6  = 7'b1011111;
    localparam logic [6:0] SEG_7  = 7'b1110000;
    localparam logic [6:0] SEG_8  = 7'b1111111;
    localparam logic [6:0] SEG_9  = 7'b1111011;
    localparam logic [6:0] SEG_HA = 7'b1110111;
    localparam logic [6:0] SEG_HB = 7'b0011111;
    localparam logic [6:0] SEG_HC = 7'b1001110;
    localparam logic [6:0] SEG_HD = 7'b0111101;
    localparam logic [6:0] SEG_HE = 7'b1001111;
    localparam logic [6:0] SEG_HF = 7'b1000111;

    localparam logic [3:0] SEG_ERR_CODE = 4'hF;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } filt_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern -> {err, code}; 0 cycles latency, no flow control.
// SEG7_HEX_DECODE_EN adds the A..F glyphs; otherwise only 0..9 are legal.
module seg7_pattern_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_err
);

    always_comb begin
        o_code = SEG_ERR_CODE;
        o_err  = 1'b1;
        case (i_seg)
            SEG_0:  begin o_code = 4'd0;  o_err = 1'b0; end
            SEG_1:  begin o_code = 4'd1;  o_err = 1'b0; end
            SEG_2:  begin o_code = 4'd2;  o_err = 1'b0; end
            SEG_3:  begin o_code = 4'd3;  o_err = 1'b0; end
            SEG_4:  begin o_code = 4'd4;  o_err = 1'b0; end
            SEG_5:  begin o_code = 4'd5;  o_err = 1'b0; end
            SEG_6:  begin o_code = 4'd6;  o_err = 1'b0; end
            SEG_7:  begin o_code = 4'd7;  o_err = 1'b0; end
            SEG_8:  begin o_code = 4'd8;  o_err = 1'b0; end
            SEG_9:  begin o_code = 4'd9;  o_err = 1'b0; end
`ifdef SEG7_HEX_DECODE_EN
            SEG_HA: begin o_code = 4'd10; o_err = 1'b0; end
            SEG_HB: begin o_code = 4'd11; o_err = 1'b0; end
            SEG_HC: begin o_code = 4'd12; o_err = 1'b0; end
            SEG_HD: begin o_code = 4'd13; o_err = 1'b0; end
            SEG_HE: begin o_code = 4'd14; o_err = 1'b0; end
            SEG_HF: begin o_code = 4'd15; o_err = 1'b0; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-seg bus, debounces each pattern, rebuilds BCD frames for a valid/ready sink.
// Commit-to-o_out_valid latency 1 clk; unaccepted frames are overwritten and flag sticky o_overrun.
// Hex glyph acceptance is enabled by defining SEG7_HEX_DECODE_EN.
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [6:0]              i_seg,
    input  logic [NUM_DIGITS-1:0]   i_dig_sel,
    output logic [4*NUM_DIGITS-1:0] o_bcd_out,
    output logic [NUM_DIGITS-1:0]   o_digit_err,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SAMP_W = NUM_DIGITS + 7;

    logic [SAMP_W-1:0]       r_samp;
    logic [SAMP_W-1:0]       w_in;
    logic                    w_changed;
    filt_state_t             r_state;
    filt_state_t             w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_commit;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [6:0]              w_seg;
    logic                    w_onehot;
    logic                    w_do_commit;
    logic [3:0]              w_code;
    logic                    w_err;
    logic [4*NUM_DIGITS-1:0] r_sh_bcd;
    logic [NUM_DIGITS-1:0]   r_sh_err;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    w_frame;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_derr;
    logic                    r_valid;
    logic                    r_overrun;

    assign w_in      = {i_dig_sel, i_seg};
    assign w_changed = (w_in != r_samp);

    // Sampled every edge, reset included, so the filter always compares against the live bus
    always_ff @(posedge i_clk) begin
        r_samp <= w_in;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_changed)
                r_cnt <= CNT_W'(1);
            else if (r_cnt != CNT_W'(STABLE_CYCLES))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_changed)
            w_state_nxt = ST_SETTLE;
        else if ((r_state == ST_SETTLE) && (r_cnt == CNT_W'(STABLE_CYCLES)))
            w_state_nxt = ST_LOCKED;
    end

    // A run that reached the stable count commits even if the bus moves on this same edge
    always_comb begin
        w_commit = (r_state == ST_SETTLE) && (r_cnt == CNT_W'(STABLE_CYCLES));
    end

    assign w_sel       = r_samp[SAMP_W-1:7];
    assign w_seg       = r_samp[6:0];
    assign w_onehot    = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
    assign w_do_commit = w_commit && w_onehot;

    seg7_pattern_decode u_decode (
        .i_seg  (w_seg),
        .o_code (w_code),
        .o_err  (w_err)
    );

    assign w_frame = &r_seen;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh_bcd <= '0;
            r_sh_err <= '0;
            r_seen   <= '0;
        end else begin
            r_seen <= (w_frame ? '0 : r_seen) | (w_do_commit ? w_sel : '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_do_commit && w_sel[i]) begin
                    r_sh_bcd[4*i +: 4] <= w_code;
                    r_sh_err[i]        <= w_err;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd     <= '0;
            r_derr    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_frame) begin
            r_bcd   <= r_sh_bcd;
            r_derr  <= r_sh_err;
            r_valid <= 1'b1;
            if (r_valid && !i_out_ready)
                r_overrun <= 1'b1;
        end else if (r_valid && i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_bcd_out   = r_bcd;
    assign o_digit_err = r_derr;
    assign o_out_valid = r_valid;
    assign o_overrun   = r_overrun;

endmodule
